// File: rtl/sqr_accum.sv
// Purpose : accumulates (x+y)^2 and x^2-1 samples into N-sample block sums
//           and presents each finished block as a held result.
// Latency : block result registered on the edge of its last sample (visible 1 cycle later).
// Backpr. : none toward upstream; a finished block is dropped (overrun set)
//           when the previous result is still held and not being taken.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid               add_sqr / sqr_m1 carry a sample this cycle
//   add_sqr [2W+1:0]       (x+y)^2, unsigned
//   sqr_m1  [2W-1:0]       x^2-1, unsigned (modulo 2^2W)
//   clr                    synchronous clear of block in progress and status
//   res_ready              downstream takes the held result
//   res_valid              result held
//   res_add_sum, res_sqr_sum  block sums, full width (no wrap)
//   overrun                sticky: a finished block was dropped
//   count                  samples already accumulated in current block
module sqr_accum #(
   parameter int W  = 8,
   parameter int N  = 16,
   localparam int CW = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [2*W+1:0]      add_sqr,
   input  logic [2*W-1:0]      sqr_m1,
   input  logic                clr,
   input  logic                res_ready,
   output logic                res_valid,
   output logic [2*W+1+CW:0]   res_add_sum,
   output logic [2*W-1+CW:0]   res_sqr_sum,
   output logic                overrun,
   output logic [CW-1:0]       count
);

   localparam int AW = 2*W + 2 + CW;
   localparam int SW = 2*W + CW;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   logic [AW-1:0] add_acc;
   logic [SW-1:0] sqr_acc;
   logic [AW-1:0] add_next;
   logic [SW-1:0] sqr_next;
   logic          blk_done;
   logic          res_load;
   logic          res_drop;
   logic          res_xfer;

   // Sums including the current sample; CW growth bits make wrap impossible
   // for up to N maximal samples.
   assign add_next = add_acc + AW'(add_sqr);
   assign sqr_next = sqr_acc + SW'(sqr_m1);

   assign blk_done = in_valid && (count == LAST_IDX);
   assign res_xfer = res_valid && res_ready;
   // A finished block may take the result slot if it is empty or being
   // emptied on this very edge; otherwise it is lost.
   assign res_load = blk_done && (!res_valid || res_ready);
   assign res_drop = blk_done && res_valid && !res_ready;

   // Block accumulation: count and running sums.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         add_acc <= '0;
         sqr_acc <= '0;
      end else if (clr) begin
         count   <= '0;
         add_acc <= '0;
         sqr_acc <= '0;
      end else if (in_valid) begin
         if (blk_done) begin
            count   <= '0;
            add_acc <= '0;
            sqr_acc <= '0;
         end else begin
            count   <= count + CW'(1);
            add_acc <= add_next;
            sqr_acc <= sqr_next;
         end
      end
   end

   // Result slot. Data registers only change on a load, so they stay stable
   // while a result is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid   <= 1'b0;
         res_add_sum <= '0;
         res_sqr_sum <= '0;
      end else if (clr) begin
         res_valid <= 1'b0;
      end else if (res_load) begin
         res_valid   <= 1'b1;
         res_add_sum <= add_next;
         res_sqr_sum <= sqr_next;
      end else if (res_xfer) begin
         res_valid <= 1'b0;
      end
   end

   // Sticky drop indicator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else if (clr) begin
         overrun <= 1'b0;
      end else if (res_drop) begin
         overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sqr_accum.sv
module tb_sqr_accum;

   localparam int W = 8;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [17:0] add_sqr;
   logic [15:0] sqr_m1;
   logic        clr;
   logic        res_ready;
   logic        res_valid;
   logic [19:0] res_add_sum;
   logic [17:0] res_sqr_sum;
   logic        overrun;
   logic [1:0]  count;

   int checks = 0;
   int errors = 0;

   // Reference model: a block is a list of samples; its result is the plain
   // sum of the list once it holds N entries.
   longint blk_add[$];
   longint blk_sqr[$];
   bit     m_vld;
   bit     m_ovr;
   longint m_ra;
   longint m_rs;

   sqr_accum #(.W(W), .N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .add_sqr     (add_sqr),
      .sqr_m1      (sqr_m1),
      .clr         (clr),
      .res_ready   (res_ready),
      .res_valid   (res_valid),
      .res_add_sum (res_add_sum),
      .res_sqr_sum (res_sqr_sum),
      .overrun     (overrun),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      blk_add.delete();
      blk_sqr.delete();
      m_vld = 0;
      m_ovr = 0;
      m_ra  = 0;
      m_rs  = 0;
   endtask

   task automatic model_edge(input bit iv, input longint a, input longint s,
                             input bit rdy, input bit c);
      longint sa;
      longint ss;
      bit     took;
      took = 0;
      if (c) begin
         blk_add.delete();
         blk_sqr.delete();
         m_vld = 0;
         m_ovr = 0;
         return;
      end
      if (iv) begin
         blk_add.push_back(a);
         blk_sqr.push_back(s);
         if (blk_add.size() == N) begin
            sa = 0;
            ss = 0;
            foreach (blk_add[i]) sa += blk_add[i];
            foreach (blk_sqr[i]) ss += blk_sqr[i];
            if (!m_vld || rdy) begin
               m_ra = sa;
               m_rs = ss;
               took = 1;
            end else begin
               m_ovr = 1;
            end
            blk_add.delete();
            blk_sqr.delete();
         end
      end
      if (took) m_vld = 1;
      else if (m_vld && rdy) m_vld = 0;
   endtask

   // Drive one cycle of inputs, advance through the rising edge, update the
   // model, and return 1 time unit after the edge.
   task automatic step(input bit iv, input logic [17:0] a, input logic [15:0] s,
                       input bit rdy, input bit c);
      in_valid  = iv;
      add_sqr   = a;
      sqr_m1    = s;
      res_ready = rdy;
      clr       = c;
      @(posedge clk);
      model_edge(iv, longint'(a), longint'(s), rdy, c);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b0 || overrun !== 1'b0 || count !== 2'd0) begin
         errors++;
         $display("FAIL reset_ctl: valid=%b ovr=%b count=%0d, want 0 0 0", res_valid, overrun, count);
      end
      checks++;
      if (res_add_sum !== 20'd0 || res_sqr_sum !== 18'd0) begin
         errors++;
         $display("FAIL reset_sums: add=%0d sqr=%0d, want 0 0", res_add_sum, res_sqr_sum);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      for (int i = 0; i < 3; i++) step(1, 18'd100, 16'd24, 1, 0);
      checks++;
      if (count !== 2'd3 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_partial: count=%0d valid=%b, want 3 0", count, res_valid);
      end
      step(1, 18'd100, 16'd24, 1, 0);
      checks++;
      if (res_valid !== 1'b1 || res_add_sum !== 20'd400 || res_sqr_sum !== 18'd96 || count !== 2'd0) begin
         errors++;
         $display("FAIL basic_result: valid=%b add=%0d sqr=%0d count=%0d, want 1 400 96 0",
                  res_valid, res_add_sum, res_sqr_sum, count);
      end
      step(0, 18'd0, 16'd0, 1, 0);
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_xfer: valid=%b, want 0", res_valid);
      end
   endtask

   task automatic test_max();
      for (int i = 0; i < 4; i++) step(1, 18'd262143, 16'd65535, 1, 0);
      checks++;
      if (res_valid !== 1'b1 || res_add_sum !== 20'd1048572 || res_sqr_sum !== 18'd262140) begin
         errors++;
         $display("FAIL max_vals: valid=%b add=%0d sqr=%0d, want 1 1048572 262140",
                  res_valid, res_add_sum, res_sqr_sum);
      end
      step(0, 18'd0, 16'd0, 1, 0);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) step(1, 18'd5, 16'd1, 0, 0);
      checks++;
      if (res_valid !== 1'b1 || res_add_sum !== 20'd20 || res_sqr_sum !== 18'd4 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL bp_first: valid=%b add=%0d sqr=%0d ovr=%b, want 1 20 4 0",
                  res_valid, res_add_sum, res_sqr_sum, overrun);
      end
      for (int i = 0; i < 4; i++) step(1, 18'd9, 16'd2, 0, 0);
      checks++;
      if (res_valid !== 1'b1 || res_add_sum !== 20'd20 || res_sqr_sum !== 18'd4 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL bp_held: valid=%b add=%0d sqr=%0d ovr=%b, want 1 20 4 1",
                  res_valid, res_add_sum, res_sqr_sum, overrun);
      end
      step(0, 18'd0, 16'd0, 1, 0);
      checks++;
      if (res_valid !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL bp_drain: valid=%b ovr=%b, want 0 1", res_valid, overrun);
      end
      step(0, 18'd0, 16'd0, 1, 1);
      checks++;
      if (overrun !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_clr: ovr=%b valid=%b, want 0 0", overrun, res_valid);
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 4; i++) step(1, 18'd3, 16'd1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 18'd6, 16'd2, 0, 0);
      step(1, 18'd6, 16'd2, 1, 0);
      checks++;
      if (res_valid !== 1'b1 || res_add_sum !== 20'd24 || res_sqr_sum !== 18'd8 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL simul: valid=%b add=%0d sqr=%0d ovr=%b, want 1 24 8 0",
                  res_valid, res_add_sum, res_sqr_sum, overrun);
      end
      step(0, 18'd0, 16'd0, 1, 0);
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL simul_drain: valid=%b, want 0", res_valid);
      end
   endtask

   task automatic test_clr();
      step(1, 18'd50, 16'd5, 1, 0);
      step(1, 18'd50, 16'd5, 1, 0);
      // clr outranks a simultaneous sample
      step(1, 18'd50, 16'd5, 1, 1);
      checks++;
      if (count !== 2'd0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL clr_count: count=%0d valid=%b, want 0 0", count, res_valid);
      end
      for (int i = 0; i < 4; i++) step(1, 18'd10, 16'd2, 1, 0);
      checks++;
      if (res_valid !== 1'b1 || res_add_sum !== 20'd40 || res_sqr_sum !== 18'd8) begin
         errors++;
         $display("FAIL clr_result: valid=%b add=%0d sqr=%0d, want 1 40 8",
                  res_valid, res_add_sum, res_sqr_sum);
      end
      step(0, 18'd0, 16'd0, 1, 0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) step(1, 18'd11, 16'd11, 1, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (count !== 2'd0 || res_valid !== 1'b0 || res_add_sum !== 20'd0) begin
         errors++;
         $display("FAIL rst_async: count=%0d valid=%b add=%0d, want 0 0 0", count, res_valid, res_add_sum);
      end
      #2 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) step(1, 18'd7, 16'd3, 1, 0);
      checks++;
      if (res_valid !== 1'b1 || res_add_sum !== 20'd28 || res_sqr_sum !== 18'd12 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: valid=%b add=%0d sqr=%0d ovr=%b, want 1 28 12 0",
                  res_valid, res_add_sum, res_sqr_sum, overrun);
      end
      step(0, 18'd0, 16'd0, 1, 0);
   endtask

   task automatic test_random();
      bit          iv;
      bit          rdy;
      bit          c;
      logic [17:0] a;
      logic [15:0] s;
      step(0, 18'd0, 16'd0, 0, 1);
      for (int n = 0; n < 400; n++) begin
         iv  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) == 0);
         c   = ($urandom_range(0, 59) == 0);
         a   = 18'($urandom);
         s   = 16'($urandom);
         step(iv, a, s, rdy, c);
         checks++;
         if (res_valid !== m_vld || overrun !== m_ovr || count !== 2'(blk_add.size())) begin
            errors++;
            $display("FAIL rand_ctl[%0d]: valid=%b ovr=%b count=%0d, want %b %b %0d",
                     n, res_valid, overrun, count, m_vld, m_ovr, blk_add.size());
         end
         if (m_vld) begin
            checks++;
            if (res_add_sum !== 20'(m_ra) || res_sqr_sum !== 18'(m_rs)) begin
               errors++;
               $display("FAIL rand_sums[%0d]: add=%0d sqr=%0d, want %0d %0d",
                        n, res_add_sum, res_sqr_sum, m_ra, m_rs);
            end
         end
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      add_sqr   = '0;
      sqr_m1    = '0;
      clr       = 1'b0;
      res_ready = 1'b0;
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_simultaneous();
      test_clr();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sqr_accum.md
SQR_ACCUM -- requirements
Module: sqr_accum

Interface
REQ-001 SHALL have parameter W, default 8: operand width of the upstream squaring pipe.
REQ-002 SHALL have parameter N, default 16: samples per accumulation block, legal range 2..1024.
REQ-003 SHALL define local width CW = clog2(N), used for accumulator growth.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1: add_sqr and sqr_m1 carry a sample this cycle.
REQ-007 SHALL have port add_sqr, input, 2W+2: (x+y)^2 from the upstream pipe, unsigned.
REQ-008 SHALL have port sqr_m1, input, 2W: x^2-1 from the upstream pipe, unsigned and modulo 2^(2W).
REQ-009 SHALL have port clr, input, 1: synchronous clear of the block in progress and of status.
REQ-010 SHALL have port res_ready, input, 1: downstream accepts the result.
REQ-011 SHALL have port res_valid, output, 1: a result is held.
REQ-012 SHALL have port res_add_sum, output, 2W+2+CW: sum of add_sqr over one block.
REQ-013 SHALL have port res_sqr_sum, output, 2W+CW: sum of sqr_m1 over one block.
REQ-014 SHALL have port overrun, output, 1: sticky flag, set when a completed block was dropped.
REQ-015 SHALL have port count, output, CW: samples already accumulated in the current block.

Function
REQ-016 SHALL, on an in_valid cycle with clr low, add add_sqr to the add accumulator and sqr_m1 to the sqr accumulator, both zero-extended, with no truncation.
REQ-017 SHALL, on an in_valid cycle with count < N-1, increment count.
REQ-018 SHALL, on an in_valid cycle with count == N-1 (block completion), clear count and both accumulators to 0 on that edge; the accumulators then restart with the next sample.
REQ-019 SHALL, on block completion while res_valid is low or res_ready is high, load accumulator-plus-current-sample into res_add_sum and res_sqr_sum and set res_valid on the same edge; the result is visible 1 cycle after the last sample.
REQ-020 SHALL, on block completion while res_valid is high and res_ready is low, leave the result registers unchanged, discard the completed block and set overrun.
REQ-021 SHALL transfer a result on a cycle where res_valid and res_ready are both high; without a simultaneous completion, res_valid clears on the next edge.
REQ-022 SHALL keep res_add_sum and res_sqr_sum stable while res_valid is high and no transfer occurs.
REQ-023 SHALL, on a cycle with clr high, zero count and both accumulators, clear res_valid and overrun, and ignore in_valid; clr has priority over every other event.
REQ-024 SHALL make the block continue accepting samples regardless of res_ready; there is no backpressure toward the upstream pipe.
REQ-025 SHALL make overrun remain set until clr or reset.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force res_valid=0, overrun=0, count=0, accumulators=0, res_add_sum=0 and res_sqr_sum=0.
REQ-027 SHALL, when reset is asserted mid-block, discard the partial block; the first in_valid after rst_n rises is sample 0 of a new block.
REQ-028 SHALL ensure reset release needs no synchronizer inside the block; deassertion is synchronized externally to clk.

Verification (W=8, N=4)
REQ-029 SHALL cover basic block: 4 samples, add_sqr=100, sqr_m1=24, res_ready=1 -> one cycle after the 4th sample, res_valid=1, res_add_sum=400, res_sqr_sum=96, then res_valid=0.
REQ-030 SHALL cover max values: 4 samples, add_sqr=262143, sqr_m1=65535 -> res_add_sum=1048572, res_sqr_sum=262140, no wrap.
REQ-031 SHALL cover backpressure: res_ready=0 across two full blocks -> first result held unchanged, overrun=1 after the 8th sample; res_ready=1 then -> first result transfers, res_valid=0.
REQ-032 SHALL cover simultaneous events: res_ready=1 in the same cycle as the 4th sample of block 2 -> block 1 transfers, block 2 loaded, res_valid stays 1, overrun stays 0.
REQ-033 SHALL cover clr mid-block: 2 samples of 50, clr, then 4 samples of 10 -> res_add_sum=40, count reads 0 after clr.
REQ-034 SHALL cover reset mid-block: 3 samples, rst_n pulsed low, then 4 samples of 7/3 -> res_add_sum=28, res_sqr_sum=12, overrun=0.
